// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction-memory req/ack channel plus the decoder-side handshake and decoded fields.
interface inst_fetch_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    logic [3:0]  pc_op;
    logic        br_taken;
    logic [31:0] rs_val;
    logic        inst_ready;

    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  hint;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        bus_err;

    modport master (
        output im_req, im_addr, inst_valid, inst, opcode, rs, rt, rd, hint, funct, imm16,
               pc, pc_plus4, bus_err,
        input  im_ack, im_rdata, pc_op, br_taken, rs_val, inst_ready
    );

    modport slave (
        input  im_req, im_addr, inst_valid, inst, opcode, rs, rt, rd, hint, funct, imm16,
               pc, pc_plus4, bus_err,
        output im_ack, im_rdata, pc_op, br_taken, rs_val, inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over req/ack, exposes decoded fields.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned fetch address raises bus_err instead of issuing a request.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [7:0]  WAIT_LIMIT = 8'd255
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    localparam logic [3:0] PC_BR = 4'd1;
    localparam logic [3:0] PC_J  = 4'd2;
    localparam logic [3:0] PC_JR = 4'd3;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_ERR} state_t;

    state_t            r_state,      w_state_nx;
    logic              r_im_req,     w_im_req_nx;
    logic              r_inst_valid, w_inst_valid_nx;
    logic [XLEN-1:0]   r_inst,       w_inst_nx;
    logic [XLEN-1:0]   r_pc,         w_pc_nx;
    logic [XLEN-1:0]   r_pc_plus4,   w_pc_plus4_nx;
    logic              r_bus_err,    w_bus_err_nx;
    logic [CNT_W-1:0]  r_cnt,        w_cnt_nx;

    logic [XLEN-1:0]   w_br_off;
    logic [XLEN-1:0]   w_next_pc;
    logic [XLEN-1:0]   w_target;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_target_bad;

    // Next-PC select from the decoder's pc_op; undefined codes fall back to sequential.
    always_comb begin
        w_br_off = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
        case (bus.pc_op)
            PC_BR:   w_next_pc = bus.br_taken ? (r_pc_plus4 + w_br_off) : r_pc_plus4;
            PC_J:    w_next_pc = {r_pc_plus4[31:28], r_inst[25:0], 2'b00};
            PC_JR:   w_next_pc = bus.rs_val;
            default: w_next_pc = r_pc_plus4;
        endcase
    end

    // Address about to be fetched: current PC out of IDLE, the new PC out of HOLD.
    assign w_target  = (r_state == S_HOLD) ? w_next_pc : r_pc;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_target_bad = (w_target[1:0] != 2'b00);
`else
    assign w_target_bad = 1'b0;
`endif

    always_comb begin
        w_state_nx      = r_state;
        w_im_req_nx     = r_im_req;
        w_inst_valid_nx = r_inst_valid;
        w_inst_nx       = r_inst;
        w_pc_nx         = r_pc;
        w_pc_plus4_nx   = r_pc_plus4;
        w_bus_err_nx    = r_bus_err;
        w_cnt_nx        = r_cnt;

        case (r_state)
            S_IDLE, S_HOLD: begin
                if (r_state == S_IDLE || bus.inst_ready) begin
                    w_pc_nx         = w_target;
                    w_pc_plus4_nx   = w_target + 32'd4;
                    w_inst_valid_nx = 1'b0;
                    w_cnt_nx        = '0;
                    if (w_target_bad) begin
                        w_state_nx   = S_ERR;
                        w_im_req_nx  = 1'b0;
                        w_bus_err_nx = 1'b1;
                    end else begin
                        w_state_nx  = S_FETCH;
                        w_im_req_nx = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (bus.im_ack) begin
                    w_state_nx      = S_HOLD;
                    w_inst_nx       = bus.im_rdata;
                    w_inst_valid_nx = 1'b1;
                    w_im_req_nx     = 1'b0;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc == WAIT_LIMIT) begin
                        w_state_nx   = S_ERR;
                        w_im_req_nx  = 1'b0;
                        w_bus_err_nx = 1'b1;
                    end
                end
            end
            S_ERR: begin
                w_im_req_nx     = 1'b0;
                w_inst_valid_nx = 1'b0;
                w_bus_err_nx    = 1'b1;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_im_req     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_pc         <= RESET_PC;
            r_pc_plus4   <= RESET_PC + 32'd4;
            r_bus_err    <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_im_req     <= w_im_req_nx;
            r_inst_valid <= w_inst_valid_nx;
            r_inst       <= w_inst_nx;
            r_pc         <= w_pc_nx;
            r_pc_plus4   <= w_pc_plus4_nx;
            r_bus_err    <= w_bus_err_nx;
            r_cnt        <= w_cnt_nx;
        end
    end

    assign bus.im_req     = r_im_req;
    assign bus.im_addr    = r_pc;
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.opcode     = r_inst[31:26];
    assign bus.rs         = r_inst[25:21];
    assign bus.rt         = r_inst[20:16];
    assign bus.rd         = r_inst[15:11];
    assign bus.hint       = r_inst[10:6];
    assign bus.funct      = r_inst[5:0];
    assign bus.imm16      = r_inst[15:0];
    assign bus.pc         = r_pc;
    assign bus.pc_plus4   = r_pc_plus4;
    assign bus.bus_err    = r_bus_err;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory/decoder driver with a PC reference model and a scoreboard monitor on inst_valid.
`timescale 1ns/1ps
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam int          WAIT_LIMIT = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(RESET_PC), .WAIT_LIMIT(8'(WAIT_LIMIT))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        mon_prev_valid = 1'b0;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_inst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural next-PC rule, written from the ISA description.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic [3:0] op, input logic tk,
                                               input logic [31:0] rsv);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(ins[15:0])) * 4;
        case (op)
            4'd1:    return tk ? seq + 32'(off) : seq;
            4'd2:    return {seq[31:28], ins[25:0], 2'b00};
            4'd3:    return rsv;
            default: return seq;
        endcase
    endfunction

    // Scoreboard: every new instruction presentation must match the oldest expected fetch.
    always @(negedge clk) begin
        if (rst) begin
            mon_prev_valid = 1'b0;
        end else begin
            if (bus.inst_valid && !mon_prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("mon_inst",   bus.inst,     mon_e.inst);
                    check("mon_pc",     bus.pc,       mon_e.pc);
                    check("mon_addr",   bus.im_addr,  mon_e.pc);
                    check("mon_pc4",    bus.pc_plus4, mon_e.pc + 32'd4);
                    check("mon_opcode", 32'(bus.opcode), 32'(mon_e.inst[31:26]));
                    check("mon_rs",     32'(bus.rs),     32'(mon_e.inst[25:21]));
                    check("mon_rt",     32'(bus.rt),     32'(mon_e.inst[20:16]));
                    check("mon_rd",     32'(bus.rd),     32'(mon_e.inst[15:11]));
                    check("mon_hint",   32'(bus.hint),   32'(mon_e.inst[10:6]));
                    check("mon_funct",  32'(bus.funct),  32'(mon_e.inst[5:0]));
                    check("mon_imm16",  32'(bus.imm16),  32'(mon_e.inst[15:0]));
                end
            end
            mon_prev_valid = bus.inst_valid;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.im_ack   = 1'b1;
        bus.im_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_pc",    bus.pc,         RESET_PC);
        check("rst_pc4",   bus.pc_plus4,   RESET_PC + 32'd4);
        check("rst_req",   32'(bus.im_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst",  bus.inst,       32'd0);
        check("rst_err",   32'(bus.bus_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        bus.im_ack = 1'b0;
        check("idle_stale_ack", 32'(bus.inst_valid), 32'd0);
        check("idle_then_req",  32'(bus.im_req),     32'd1);
        m_pc = RESET_PC;
        exp_q.delete();
    endtask

    task automatic serve(input logic [31:0] rdata, input int dly);
        int t;
        t = 0;
        while (bus.im_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("req_rise", 32'(bus.im_req), 32'd1);
        check("im_addr",  bus.im_addr,     m_pc);
        for (int i = 0; i < dly; i++) begin
            bus.im_ack = 1'b0;
            @(negedge clk);
        end
        if (dly > 0) begin
            check("req_held",    32'(bus.im_req), 32'd1);
            check("addr_stable", bus.im_addr,     m_pc);
        end
        bus.im_ack   = 1'b1;
        bus.im_rdata = rdata;
        exp_q.push_back('{pc: m_pc, inst: rdata});
        @(negedge clk);
        bus.im_ack   = 1'b0;
        bus.im_rdata = $urandom;
        check("valid_after_ack", 32'(bus.inst_valid), 32'd1);
        check("req_drop",        32'(bus.im_req),     32'd0);
        m_inst = rdata;
    endtask

    task automatic accept(input int hold, input logic [3:0] op, input logic tk, input logic [31:0] rsv);
        for (int i = 0; i < hold; i++) begin
            bus.im_ack   = 1'($urandom);
            bus.im_rdata = $urandom;
            bus.pc_op    = 4'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(bus.inst_valid), 32'd1);
            check("hold_inst",  bus.inst,            m_inst);
            check("hold_noreq", 32'(bus.im_req),     32'd0);
        end
        bus.im_ack     = 1'b0;
        bus.pc_op      = op;
        bus.br_taken   = tk;
        bus.rs_val     = rsv;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        bus.pc_op      = 4'($urandom);
        bus.br_taken   = 1'($urandom);
        bus.rs_val     = $urandom;
        m_pc = model_next(m_pc, m_inst, op, tk, rsv);
        check("valid_drop", 32'(bus.inst_valid), 32'd0);
        check("pc_update",  bus.pc,              m_pc);
    endtask

    initial begin
        int  cyc;
        logic req_ok;
        rst = 1'b1;
        bus.im_ack = 1'b0; bus.im_rdata = '0; bus.pc_op = '0;
        bus.br_taken = 1'b0; bus.rs_val = '0; bus.inst_ready = 1'b0;
        do_reset();

        // T1: first fetch from reset vector, then sequential
        serve(32'h0000_0020, 0);
        check("t1_opcode", 32'(bus.opcode), 32'd0);
        check("t1_funct",  32'(bus.funct),  32'h20);
        accept(0, 4'd0, 1'b0, 32'd0);
        check("t1_next_addr", bus.im_addr, 32'h0000_3004);

        // T2: backward branch taken / not taken from 0x3010
        serve($urandom, 1);
        accept(0, 4'd3, 1'b0, 32'h0000_3010);
        serve(32'h1000_FFFF, 2);
        accept(1, 4'd1, 1'b1, 32'd0);
        check("t2_taken", bus.pc, 32'h0000_3010);
        serve(32'h1000_FFFF, 0);
        accept(0, 4'd1, 1'b0, 32'd0);
        check("t2_not_taken", bus.pc, 32'h0000_3014);

        // T3: jump from 0x3000
        serve($urandom, 0);
        accept(0, 4'd3, 1'b0, 32'h0000_3000);
        serve(32'h0C00_0100, 0);
        check("t3_pc4", bus.pc_plus4, 32'h0000_3004);
        accept(0, 4'd2, 1'b0, 32'd0);
        check("t3_jump", bus.pc, 32'h0000_0400);

        // T4: register jump with a long stall
        serve($urandom, 3);
        accept(5, 4'd3, 1'b0, 32'h0000_4008);
        check("t4_jr_addr", bus.im_addr, 32'h0000_4008);

        // PC wrap at the top of the address space
        serve($urandom, 0);
        accept(0, 4'd3, 1'b0, 32'hFFFF_FFFC);
        serve($urandom, 0);
        check("wrap_pc4", bus.pc_plus4, 32'd0);
        accept(0, 4'd0, 1'b0, 32'd0);
        check("wrap_pc", bus.pc, 32'd0);

        // Randomized traffic, all targets word aligned
        for (int n = 0; n < 150; n++) begin
            serve($urandom, int'($urandom_range(0, 6)));
            accept(int'($urandom_range(0, 4)), 4'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC);
        end

        // T6: misaligned register jump
        serve($urandom, 0);
        accept(0, 4'd3, 1'b0, 32'h0000_4002);
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6_err",   32'(bus.bus_err), 32'd1);
        check("t6_noreq", 32'(bus.im_req),  32'd0);
        repeat (3) @(negedge clk);
        check("t6_noreq_later", 32'(bus.im_req), 32'd0);
        do_reset();
`else
        check("t6_addr",  bus.im_addr,      32'h0000_4002);
        check("t6_noerr", 32'(bus.bus_err), 32'd0);
        serve($urandom, 0);
        accept(0, 4'd0, 1'b0, 32'd0);
`endif

        // T5: memory never acknowledges
        serve($urandom, 0);
        accept(0, 4'd0, 1'b0, 32'd0);
        check("t5_req", 32'(bus.im_req), 32'd1);
        cyc = 0;
        req_ok = 1'b1;
        while (!bus.bus_err && cyc < WAIT_LIMIT + 20) begin
            @(negedge clk);
            cyc++;
            if (!bus.bus_err && !bus.im_req) req_ok = 1'b0;
        end
        check("t5_req_held", 32'(req_ok), 32'd1);
        check("t5_latency",  32'(cyc),    32'(WAIT_LIMIT));
        check("t5_req_off",  32'(bus.im_req),     32'd0);
        check("t5_valid",    32'(bus.inst_valid), 32'd0);
        bus.im_ack = 1'b1;
        repeat (3) @(negedge clk);
        bus.im_ack = 1'b0;
        check("t5_late_ack_err",   32'(bus.bus_err),    32'd1);
        check("t5_late_ack_valid", 32'(bus.inst_valid), 32'd0);
        check("t5_late_ack_req",   32'(bus.im_req),     32'd0);
        do_reset();
        check("t5_restart_addr", bus.im_addr, 32'h0000_3000);
        serve($urandom, 1);
        accept(0, 4'd0, 1'b0, 32'd0);

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
